ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 145 ++++++++++++++
 tb/tb_ram_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-requester single-port RAM arbiter: instruction fetch vs. load/store, one transaction in flight.
// Optional starvation guard for fetch is enabled by defining ARB_STARVE_GUARD_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ZERO
`define ZERO '0
`endif

// state  | meaning
// IDLE   | no transaction in flight; grant a pending request this cycle
// WAIT_I | fetch granted last cycle; RAM data returns, pulse inst_ack_o
// WAIT_D | load/store granted last cycle; pulse data_ack_o
module ram_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   inst_req_i,
   input  logic [`ADDR_WIDTH-1:0] inst_addr_i,
   output logic                   inst_ack_o,
   output logic [`DATA_WIDTH-1:0] inst_rdata_o,
   input  logic                   data_req_i,
   input  logic                   data_we_i,
   input  logic [`ADDR_WIDTH-1:0] data_addr_i,
   input  logic [`DATA_WIDTH-1:0] data_wdata_i,
   output logic                   data_ack_o,
   output logic [`DATA_WIDTH-1:0] data_rdata_o,
   output logic                   ram_en_o,
   output logic                   ram_we_o,
   output logic [`ADDR_WIDTH-1:0] ram_addr_o,
   output logic [`DATA_WIDTH-1:0] ram_wdata_o,
   input  logic [`DATA_WIDTH-1:0] ram_rdata_i
);

   typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

   state_t state_q, state_d;
   logic   we_q, we_d;
   logic   starve_hit;
   logic   grant_data;
   logic   grant_inst;

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
      $error("ram_arbiter: STARVE_LIMIT must be within 1..15");
   end

`ifdef ARB_STARVE_GUARD_EN
   logic [3:0] cnt_q, cnt_d;

   assign starve_hit = (cnt_q == 4'(STARVE_LIMIT));

   // Counts data grants that bypassed a waiting fetch; any fetch grant resets it.
   always_comb begin
      cnt_d = cnt_q;
      if (grant_inst) begin
         cnt_d = 4'd0;
      end else if (grant_data && inst_req_i && (cnt_q != 4'd15)) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign starve_hit = 1'b0;
`endif

   assign grant_data = (state_q == IDLE) && data_req_i && !(inst_req_i && starve_hit);
   assign grant_inst = (state_q == IDLE) && inst_req_i && !grant_data;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
      end
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      case (state_q)
         IDLE: begin
            if (grant_data) begin
               state_d = WAIT_D;
               we_d    = data_we_i;
            end else if (grant_inst) begin
               state_d = WAIT_I;
               we_d    = 1'b0;
            end
         end
         WAIT_I:  state_d = IDLE;
         WAIT_D:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are forced to zero during reset even though the state register updates only on the edge.
   always_comb begin
      inst_ack_o   = 1'b0;
      inst_rdata_o = `ZERO;
      data_ack_o   = 1'b0;
      data_rdata_o = `ZERO;
      ram_en_o     = 1'b0;
      ram_we_o     = 1'b0;
      ram_addr_o   = `ZERO;
      ram_wdata_o  = `ZERO;
      if (!rst_i) begin
         case (state_q)
            IDLE: begin
               if (grant_data) begin
                  ram_en_o    = 1'b1;
                  ram_we_o    = data_we_i;
                  ram_addr_o  = data_addr_i;
                  ram_wdata_o = data_wdata_i;
               end else if (grant_inst) begin
                  ram_en_o    = 1'b1;
                  ram_addr_o  = inst_addr_i;
               end
            end
            WAIT_I: begin
               inst_ack_o   = 1'b1;
               inst_rdata_o = ram_rdata_i;
            end
            WAIT_D: begin
               data_ack_o   = 1'b1;
               data_rdata_o = we_q ? `ZERO : ram_rdata_i;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: per-cycle vector table plus a held-request arbitration sequence.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_ram_arbiter;

   logic                   clk_i = 1'b0;
   logic                   rst_i;
   logic                   inst_req_i;
   logic [`ADDR_WIDTH-1:0] inst_addr_i;
   logic                   inst_ack_o;
   logic [`DATA_WIDTH-1:0] inst_rdata_o;
   logic                   data_req_i;
   logic                   data_we_i;
   logic [`ADDR_WIDTH-1:0] data_addr_i;
   logic [`DATA_WIDTH-1:0] data_wdata_i;
   logic                   data_ack_o;
   logic [`DATA_WIDTH-1:0] data_rdata_o;
   logic                   ram_en_o;
   logic                   ram_we_o;
   logic [`ADDR_WIDTH-1:0] ram_addr_o;
   logic [`DATA_WIDTH-1:0] ram_wdata_o;
   logic [`DATA_WIDTH-1:0] ram_rdata_i;

   int checks   = 0;
   int failures = 0;

   ram_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .inst_req_i   (inst_req_i),
      .inst_addr_i  (inst_addr_i),
      .inst_ack_o   (inst_ack_o),
      .inst_rdata_o (inst_rdata_o),
      .data_req_i   (data_req_i),
      .data_we_i    (data_we_i),
      .data_addr_i  (data_addr_i),
      .data_wdata_i (data_wdata_i),
      .data_ack_o   (data_ack_o),
      .data_rdata_o (data_rdata_o),
      .ram_en_o     (ram_en_o),
      .ram_we_o     (ram_we_o),
      .ram_addr_o   (ram_addr_o),
      .ram_wdata_o  (ram_wdata_o),
      .ram_rdata_i  (ram_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        rst;
      logic        ireq;
      logic [31:0] iaddr;
      logic        dreq;
      logic        dwe;
      logic [31:0] daddr;
      logic [31:0] dwdata;
      logic [31:0] rr;
      logic        iack;
      logic [31:0] irdata;
      logic        dack;
      logic [31:0] drdata;
      logic        en;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rst, logic ireq, logic [31:0] iaddr, logic dreq, logic dwe,
                               logic [31:0] daddr, logic [31:0] dwdata, logic [31:0] rr,
                               logic iack, logic [31:0] irdata, logic dack, logic [31:0] drdata,
                               logic en, logic we, logic [31:0] addr, logic [31:0] wdata);
      vec_t v;
      v.rst = rst; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe;
      v.daddr = daddr; v.dwdata = dwdata; v.rr = rr;
      v.iack = iack; v.irdata = irdata; v.dack = dack; v.drdata = drdata;
      v.en = en; v.we = we; v.addr = addr; v.wdata = wdata;
      return v;
   endfunction

   task automatic drive(logic rst, logic ireq, logic [31:0] iaddr, logic dreq, logic dwe,
                        logic [31:0] daddr, logic [31:0] dwdata, logic [31:0] rr);
      rst_i = rst; inst_req_i = ireq; inst_addr_i = iaddr; data_req_i = dreq;
      data_we_i = dwe; data_addr_i = daddr; data_wdata_i = dwdata; ram_rdata_i = rr;
   endtask

   task automatic check_bit(string name, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic check_word(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   initial begin
      logic [131:0] got;
      logic [131:0] exp;
      bit           guard_en;
      logic         exp_inst;

`ifdef ARB_STARVE_GUARD_EN
      guard_en = 1'b1;
`else
      guard_en = 1'b0;
`endif

      //                rst ireq iaddr     dreq dwe daddr     dwdata        rr            iack irdata        dack drdata        en we addr      wdata
      vecs.push_back(mk(1, 1, 32'h0000_0100, 1, 1, 32'h200, 32'hDEADBEEF, 32'h0000_0011, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0));
      vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,   32'h0,        32'h0000_0022, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0));
      vecs.push_back(mk(0, 1, 32'h0000_0100, 0, 0, 32'h0,   32'h0,        32'h0,         0, 32'h0,        0, 32'h0,        1, 0, 32'h100, 32'h0));
      vecs.push_back(mk(0, 1, 32'h0000_0100, 0, 0, 32'h0,   32'h0,        32'h0000_0013, 1, 32'h13,       0, 32'h0,        0, 0, 32'h0,   32'h0));
      vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,   32'h0,        32'h0000_0055, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0));
      vecs.push_back(mk(0, 0, 32'h0,         1, 1, 32'h200, 32'hDEADBEEF, 32'h0,         0, 32'h0,        0, 32'h0,        1, 1, 32'h200, 32'hDEADBEEF));
      vecs.push_back(mk(0, 0, 32'h0,         1, 1, 32'h200, 32'hDEADBEEF, 32'h0000_0077, 0, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0));
      vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h200, 32'h0000_1234, 32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 32'h200, 32'h1234));
      vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h200, 32'h0000_1234, 32'hDEADBEEF, 0, 32'h0,        1, 32'hDEADBEEF, 0, 0, 32'h0,   32'h0));
      vecs.push_back(mk(0, 1, 32'h0000_0104, 1, 0, 32'h300, 32'h0,        32'h0,         0, 32'h0,        0, 32'h0,        1, 0, 32'h300, 32'h0));
      vecs.push_back(mk(0, 1, 32'h0000_0104, 1, 1, 32'h3F0, 32'h0,        32'h0000_00AA, 0, 32'h0,        1, 32'hAA,       0, 0, 32'h0,   32'h0));
      vecs.push_back(mk(0, 1, 32'h0000_0104, 0, 0, 32'h0,   32'h0,        32'h0,         0, 32'h0,        0, 32'h0,        1, 0, 32'h104, 32'h0));
      vecs.push_back(mk(0, 1, 32'h0000_0777, 1, 1, 32'h999, 32'h5555,     32'h0000_00BB, 1, 32'hBB,       0, 32'h0,        0, 0, 32'h0,   32'h0));
      vecs.push_back(mk(0, 0, 32'h0,         1, 0, 32'h400, 32'h0,        32'h0,         0, 32'h0,        0, 32'h0,        1, 0, 32'h400, 32'h0));
      vecs.push_back(mk(1, 0, 32'h0,         1, 0, 32'h400, 32'h0,        32'h0000_00CC, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0));
      vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,   32'h0,        32'h0000_00CC, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0));
      vecs.push_back(mk(0, 1, 32'h0000_0108, 0, 0, 32'h0,   32'h0,        32'h0,         0, 32'h0,        0, 32'h0,        1, 0, 32'h108, 32'h0));
      vecs.push_back(mk(1, 1, 32'h0000_0108, 0, 0, 32'h0,   32'h0,        32'h0000_00DD, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0));
      vecs.push_back(mk(0, 0, 32'h0,         0, 0, 32'h0,   32'h0,        32'h0000_00DD, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0));

      #1;
      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].dwe,
               vecs[i].daddr, vecs[i].dwdata, vecs[i].rr);
         @(negedge clk_i);
         got = {inst_ack_o, inst_rdata_o, data_ack_o, data_rdata_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o[31:0]};
         exp = {vecs[i].iack, vecs[i].irdata, vecs[i].dack, vecs[i].drdata, vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL vec%0d: got iack=%0b ird=%08h dack=%0b drd=%08h en=%0b we=%0b addr=%08h wd=%08h required iack=%0b ird=%08h dack=%0b drd=%08h en=%0b we=%0b addr=%08h wd=%08h",
                     i, inst_ack_o, inst_rdata_o, data_ack_o, data_rdata_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o,
                     vecs[i].iack, vecs[i].irdata, vecs[i].dack, vecs[i].drdata, vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
         end
         @(posedge clk_i);
         #1;
      end

      // Both requesters held continuously: grant order depends on the starvation guard.
      drive(0, 1, 32'h500, 1, 0, 32'h600, 32'h0, 32'h0000_0F0F);
      for (int g = 0; g < 10; g++) begin
         exp_inst = guard_en && ((g % 5) == 4);
         @(negedge clk_i);
         check_bit($sformatf("starve_en_g%0d", g), ram_en_o, 1'b1);
         check_word($sformatf("starve_addr_g%0d", g), ram_addr_o, exp_inst ? 32'h500 : 32'h600);
         @(posedge clk_i);
         #1;
         @(negedge clk_i);
         check_bit($sformatf("starve_iack_g%0d", g), inst_ack_o, exp_inst);
         check_bit($sformatf("starve_dack_g%0d", g), data_ack_o, !exp_inst);
         @(posedge clk_i);
         #1;
      end
      drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
